// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty codes, measurement FSM encodings and the
// shift-add duty classifier used by the decoder and the PWM generator.
package pwm_pkg;

    localparam logic [1:0] DUTY_25  = 2'b00;
    localparam logic [1:0] DUTY_50  = 2'b01;
    localparam logic [1:0] DUTY_75  = 2'b10;
    localparam logic [1:0] DUTY_100 = 2'b11;

    // Class boundaries are k/8 of the period: 3/8, 5/8, 7/8
    localparam logic [2:0] K_25_50  = 3'd3;
    localparam logic [2:0] K_50_75  = 3'd5;
    localparam logic [2:0] K_75_100 = 3'd7;

    localparam int unsigned MATH_W = 40;

    typedef enum logic [1:0] {
        ST_WAIT_RISE = 2'b00,
        ST_MEAS_HIGH = 2'b01,
        ST_MEAS_LOW  = 2'b10
    } dec_state_t;

    function automatic logic [MATH_W-1:0] mul_small(
        input logic [MATH_W-1:0] x,
        input logic [2:0]        k
    );
        logic [MATH_W-1:0] acc;
        acc = {MATH_W{1'b0}};
        if (k[0]) acc = acc + x;
        else      acc = acc;
        if (k[1]) acc = acc + (x << 2'd1);
        else      acc = acc;
        if (k[2]) acc = acc + (x << 2'd2);
        else      acc = acc;
        return acc;
    endfunction

    function automatic logic [1:0] classify_duty(
        input logic [MATH_W-1:0] high,
        input logic [MATH_W-1:0] period
    );
        logic [MATH_W-1:0] high_x8;
        logic [1:0]        code;
        high_x8 = high << 3'd3;
        if (high_x8 < mul_small(period, K_25_50))       code = DUTY_25;
        else if (high_x8 < mul_small(period, K_50_75))  code = DUTY_50;
        else if (high_x8 < mul_small(period, K_75_100)) code = DUTY_75;
        else                                            code = DUTY_100;
        return code;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-stage synchronizer for an asynchronous line followed by a registered
// edge detector; level is aligned with the rise/fall pulses.
module pwm_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;

    // synchronizer stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d_in;
            sync_r <= meta_r;
        end
    end

    // registered level and one-cycle edge pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= sync_r;
            rise  <= sync_r & ~level;
            fall  <= ~sync_r & level;
        end
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an asynchronous PWM line and decodes a
// 2-bit duty class. Define PWM_DEC_TIMEOUT_EN to add the stuck-line timeout.
module pwm_duty_decoder #(
    parameter int CLK_FREQ_HZ = 32'd100_000_000,
    parameter int PWM_FREQ_HZ = 32'd50,
    localparam int NOM   = CLK_FREQ_HZ / PWM_FREQ_HZ,
    localparam int CNT_W = $clog2(32'd2 * NOM + 32'd1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [1:0]       duty_sel,
    output logic             duty_valid,
    output logic             sample_stb,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             line_err
);

    import pwm_pkg::*;

    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(32'd2 * NOM);
    localparam logic [CNT_W-1:0] MIN_P_C = CNT_W'(NOM / 32'd2);
    localparam logic [CNT_W-1:0] MAX_P_C = CNT_W'((32'd3 * NOM) / 32'd2);
    localparam int               PAD_W   = MATH_W - CNT_W;

    logic             level_s;
    logic             rise_raw_s;
    logic             fall_raw_s;
    logic             rise_s;
    logic             fall_s;
    dec_state_t       state_r;
    logic [CNT_W-1:0] period_cnt_r;
    logic [CNT_W-1:0] high_cnt_r;
    logic [CNT_W-1:0] period_inc_s;
    logic [CNT_W-1:0] high_inc_s;
    logic             period_ok_s;
    logic [1:0]       duty_s;

    pwm_sync_edge u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (pwm_in),
        .level   (level_s),
        .rise    (rise_raw_s),
        .fall    (fall_raw_s)
    );

    // qualified edges, saturating increments and evaluation of the finished period
    always_comb begin
        rise_s = rise_raw_s & level_s;
        fall_s = fall_raw_s & ~level_s;
        if (period_cnt_r >= SAT_C) period_inc_s = SAT_C;
        else                       period_inc_s = period_cnt_r + ONE_C;
        if (high_cnt_r >= SAT_C)   high_inc_s = SAT_C;
        else                       high_inc_s = high_cnt_r + ONE_C;
        period_ok_s = (period_cnt_r >= MIN_P_C) && (period_cnt_r <= MAX_P_C);
        duty_s = classify_duty({{PAD_W{1'b0}}, high_cnt_r}, {{PAD_W{1'b0}}, period_cnt_r});
    end

`ifdef PWM_DEC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_C      = CNT_W'((32'd3 * NOM) / 32'd2);
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'((32'd3 * NOM) / 32'd2 - 32'd1);

    logic [CNT_W-1:0] idle_cnt_r;
    logic             timeout_s;

    // cycles without a synchronized edge; parks at the limit so the timeout fires once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_r <= ZERO_C;
        end else if (rise_s || fall_s) begin
            idle_cnt_r <= ZERO_C;
        end else if (idle_cnt_r < TO_C) begin
            idle_cnt_r <= idle_cnt_r + ONE_C;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // fires in the cycle that completes the idle window
    always_comb begin
        timeout_s = (idle_cnt_r == TO_LAST_C) && !(rise_s || fall_s);
    end
`endif

    // measurement FSM with registered results; evaluation uses the counts
    // before the restart that the same rise causes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_WAIT_RISE;
            period_cnt_r <= ZERO_C;
            high_cnt_r   <= ZERO_C;
            duty_sel     <= DUTY_25;
            duty_valid   <= 1'b0;
            sample_stb   <= 1'b0;
            period_out   <= ZERO_C;
            high_out     <= ZERO_C;
            line_err     <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
`ifdef PWM_DEC_TIMEOUT_EN
            if (timeout_s) begin
                state_r      <= ST_WAIT_RISE;
                period_cnt_r <= ZERO_C;
                high_cnt_r   <= ZERO_C;
                if (level_s) begin
                    duty_sel   <= DUTY_100;
                    duty_valid <= 1'b1;
                    sample_stb <= 1'b1;
                end else begin
                    duty_valid <= 1'b0;
                    line_err   <= 1'b1;
                end
            end else begin
`endif
            case (state_r)
                ST_WAIT_RISE: begin
                    if (rise_s) begin
                        state_r      <= ST_MEAS_HIGH;
                        period_cnt_r <= ONE_C;
                        high_cnt_r   <= ONE_C;
                    end else begin
                        period_cnt_r <= ZERO_C;
                        high_cnt_r   <= ZERO_C;
                    end
                end
                ST_MEAS_HIGH: begin
                    if (rise_s) begin
                        // fall was missed: discard this period and start over
                        line_err     <= 1'b1;
                        period_cnt_r <= ONE_C;
                        high_cnt_r   <= ONE_C;
                    end else if (fall_s) begin
                        state_r      <= ST_MEAS_LOW;
                        period_cnt_r <= period_inc_s;
                    end else begin
                        period_cnt_r <= period_inc_s;
                        high_cnt_r   <= high_inc_s;
                    end
                end
                ST_MEAS_LOW: begin
                    if (rise_s) begin
                        state_r      <= ST_MEAS_HIGH;
                        period_cnt_r <= ONE_C;
                        high_cnt_r   <= ONE_C;
                        if (period_ok_s) begin
                            period_out <= period_cnt_r;
                            high_out   <= high_cnt_r;
                            duty_sel   <= duty_s;
                            duty_valid <= 1'b1;
                            sample_stb <= 1'b1;
                        end else begin
                            line_err <= 1'b1;
                        end
                    end else begin
                        period_cnt_r <= period_inc_s;
                    end
                end
                default: begin
                    state_r      <= ST_WAIT_RISE;
                    period_cnt_r <= ZERO_C;
                    high_cnt_r   <= ZERO_C;
                end
            endcase
`ifdef PWM_DEC_TIMEOUT_EN
            end
`endif
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder at NOM=100: vector table, directed
// corner sequences and a randomized stream checked against a ratio-based model.
module tb_pwm_duty_decoder;

    localparam int NOM = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pwm_in;
    logic [1:0] duty_sel;
    logic       duty_valid;
    logic       sample_stb;
    logic [7:0] period_out;
    logic [7:0] high_out;
    logic       line_err;

    always #5 clk = ~clk;

    pwm_duty_decoder #(
        .CLK_FREQ_HZ (1000),
        .PWM_FREQ_HZ (10)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pwm_in     (pwm_in),
        .duty_sel   (duty_sel),
        .duty_valid (duty_valid),
        .sample_stb (sample_stb),
        .period_out (period_out),
        .high_out   (high_out),
        .line_err   (line_err)
    );

    typedef struct {
        int high;
        int period;
        int exp_duty;
        bit exp_acc;
    } vec_t;

    typedef struct {
        int period;
        int high;
        int duty;
        int valid;
    } obs_t;

    vec_t vecs[$];
    obs_t stb_q[$];
    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // model state: the period currently being measured (ends at the next rise)
    bit   m_have_prev;
    int   m_prev_h;
    int   m_prev_p;
    int   m_err;

    // record every strobe seen on the outputs
    always @(negedge clk) begin : mon
        obs_t o;
        if (reset_n === 1'b1 && sample_stb === 1'b1) begin
            o.period = int'(period_out);
            o.high   = int'(high_out);
            o.duty   = int'(duty_sel);
            o.valid  = int'(duty_valid);
            stb_q.push_back(o);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int duty_of(input int h, input int p);
        real r;
        r = real'(h) / real'(p);
        if (r < 0.375)      return 0;
        else if (r < 0.625) return 1;
        else if (r < 0.875) return 2;
        else                return 3;
    endfunction

    task automatic drive_period(input int h, input int p);
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            pwm_in = (i < h) ? 1'b1 : 1'b0;
        end
    endtask

    // every rise closes the previous period; accepted ones produce an update
    task automatic play(input int h, input int p);
        obs_t e;
        if (m_have_prev) begin
            if (m_prev_p >= NOM / 2 && m_prev_p <= 3 * NOM / 2) begin
                e.period = m_prev_p;
                e.high   = m_prev_h;
                e.duty   = duty_of(m_prev_h, m_prev_p);
                e.valid  = 1;
                exp_q.push_back(e);
            end else begin
                m_err = 1;
            end
        end
        m_have_prev = 1'b1;
        m_prev_h    = h;
        m_prev_p    = p;
        drive_period(h, p);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        pwm_in  = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        stb_q.delete();
        exp_q.delete();
        m_have_prev = 1'b0;
        m_err       = 0;
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_count"}, stb_q.size(), exp_q.size());
        for (int i = 0; i < stb_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_duty"},   stb_q[i].duty,   exp_q[i].duty);
            chk({tag, "_period"}, stb_q[i].period, exp_q[i].period);
            chk({tag, "_high"},   stb_q[i].high,   exp_q[i].high);
            chk({tag, "_valid"},  stb_q[i].valid,  exp_q[i].valid);
        end
        chk({tag, "_line_err"}, int'(line_err), m_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_duty_sel"},   int'(duty_sel),   0);
        chk({tag, "_duty_valid"}, int'(duty_valid), 0);
        chk({tag, "_sample_stb"}, int'(sample_stb), 0);
        chk({tag, "_period_out"}, int'(period_out), 0);
        chk({tag, "_high_out"},   int'(high_out),   0);
        chk({tag, "_line_err"},   int'(line_err),   0);
    endtask

    initial begin
        int p;
        int h;
        int lo;
        int hi;
        int idx;

        vecs.push_back('{25, 100, 0, 1'b1});
        vecs.push_back('{75, 100, 2, 1'b1});
        vecs.push_back('{40, 100, 1, 1'b1});
        vecs.push_back('{37, 100, 0, 1'b1});
        vecs.push_back('{38, 100, 1, 1'b1});
        vecs.push_back('{62, 100, 1, 1'b1});
        vecs.push_back('{63, 100, 2, 1'b1});
        vecs.push_back('{87, 100, 2, 1'b1});
        vecs.push_back('{88, 100, 3, 1'b1});
        vecs.push_back('{99, 100, 3, 1'b1});
        vecs.push_back('{20, 40, 0, 1'b0});
        vecs.push_back('{24, 49, 0, 1'b0});
        vecs.push_back('{25, 50, 1, 1'b1});
        vecs.push_back('{100, 150, 2, 1'b1});
        vecs.push_back('{100, 151, 0, 1'b0});
        vecs.push_back('{10, 60, 0, 1'b1});

        // reset state
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        // steady 25% at nominal period
        apply_reset();
        repeat (3) play(25, 100);
        play(25, 100);
        compare_stream("d25");
        chk("d25_duty_sel", int'(duty_sel), 0);
        chk("d25_period_out", int'(period_out), 100);
        chk("d25_high_out", int'(high_out), 25);

        // 75% then 40%
        apply_reset();
        play(75, 100);
        play(40, 100);
        play(50, 100);
        compare_stream("d75_40");
        if (stb_q.size() >= 2) begin
            chk("d75_first_duty", stb_q[0].duty, 2);
            chk("d40_second_duty", stb_q[1].duty, 1);
        end else begin
            chk("d75_40_strobes", stb_q.size(), 2);
        end
        chk("d75_40_valid", int'(duty_valid), 1);

        // short period between nominal ones
        apply_reset();
        play(50, 100);
        play(20, 40);
        play(50, 100);
        play(50, 100);
        compare_stream("short");
        chk("short_line_err", int'(line_err), 1);

        // vector table streamed back to back, followed by a closing period
        apply_reset();
        foreach (vecs[i]) drive_period(vecs[i].high, vecs[i].period);
        drive_period(50, 100);
        idx = 0;
        foreach (vecs[i]) begin
            if (vecs[i].exp_acc) begin
                if (idx < stb_q.size()) begin
                    chk($sformatf("vec%0d_duty", i),   stb_q[idx].duty,   vecs[i].exp_duty);
                    chk($sformatf("vec%0d_period", i), stb_q[idx].period, vecs[i].period);
                    chk($sformatf("vec%0d_high", i),   stb_q[idx].high,   vecs[i].high);
                end else begin
                    chk($sformatf("vec%0d_missing", i), idx, stb_q.size());
                end
                idx++;
            end
        end
        chk("vec_count", stb_q.size(), idx);
        chk("vec_line_err", int'(line_err), 1);

        // randomized stream against the ratio model
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            p  = $urandom_range(170, 30);
            lo = (p - 140 > 1) ? p - 140 : 1;
            hi = (p - 1 < 140) ? p - 1 : 140;
            h  = $urandom_range(hi, lo);
            play(h, p);
        end
        play(50, 100);
        compare_stream("rand");

        // reset in the middle of a period
        apply_reset();
        drive_period(50, 100);
        drive_period(50, 100);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            pwm_in = (i < 25) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) @(negedge clk);
        pwm_in  = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        stb_q.delete();
        drive_period(50, 100);
        chk("midrst_no_stb_after_first_rise", stb_q.size(), 0);
        drive_period(50, 100);
        chk("midrst_stb_after_second_rise", stb_q.size(), 1);
        chk("midrst_duty_sel", int'(duty_sel), 1);
        chk("midrst_period_out", int'(period_out), 100);
        chk("midrst_high_out", int'(high_out), 50);

        // stuck line high, then low
        apply_reset();
        drive_period(50, 100);
        drive_period(50, 100);
        stb_q.delete();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            pwm_in = 1'b1;
        end
`ifdef PWM_DEC_TIMEOUT_EN
        chk("stuck1_strobes", stb_q.size(), 2);
        chk("stuck1_duty_sel", int'(duty_sel), 3);
        chk("stuck1_duty_valid", int'(duty_valid), 1);
`else
        chk("stuck1_strobes", stb_q.size(), 1);
        chk("stuck1_duty_sel", int'(duty_sel), 1);
        chk("stuck1_duty_valid", int'(duty_valid), 1);
`endif
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            pwm_in = 1'b0;
        end
`ifdef PWM_DEC_TIMEOUT_EN
        chk("stuck0_strobes", stb_q.size(), 2);
        chk("stuck0_duty_valid", int'(duty_valid), 0);
        chk("stuck0_line_err", int'(line_err), 1);
`else
        chk("stuck0_strobes", stb_q.size(), 1);
        chk("stuck0_duty_valid", int'(duty_valid), 1);
        chk("stuck0_line_err", int'(line_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter PWM_FREQ_HZ, default 50, meaning nominal input PWM frequency in Hz; NOM = CLK_FREQ_HZ/PWM_FREQ_HZ clock cycles per period.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pwm_in, input, 1, asynchronous PWM line to decode.
REQ-006 SHALL have port duty_sel, output, 2, decoded duty code: 00=25%, 01=50%, 10=75%, 11=100%.
REQ-007 SHALL have port duty_valid, output, 1, high while duty_sel holds a valid decoded value.
REQ-008 SHALL have port sample_stb, output, 1, one-cycle pulse on every duty_sel/period_out/high_out update.
REQ-009 SHALL have ports period_out and high_out, output, CNT_W each, last accepted period and high-time in clk cycles; CNT_W = $clog2(2*NOM+1).
REQ-010 SHALL have port line_err, output, 1, sticky flag for a rejected period or a lost line.

Function
REQ-011 SHALL pass pwm_in through a 2-FF synchronizer, then a 1-cycle edge detector that produces rise and fall pulses.
REQ-012 SHALL use FSM states WAIT_RISE -> MEAS_HIGH (on rise) -> MEAS_LOW (on fall) -> MEAS_HIGH (on rise, evaluate).
REQ-013 SHALL start period_cnt and high_cnt at 1 in the cycle after a rise pulse; high_cnt freezes on the fall pulse; period_cnt counts until the next rise pulse; both saturate at 2*NOM.
REQ-014 SHALL, on a rise pulse in MEAS_LOW, register the outputs in the next cycle: period_out, high_out, duty_sel, duty_valid=1, and sample_stb=1 for that single cycle.
REQ-015 SHALL classify with shift-add math only, no divider: 8*high < 3*period gives 00; < 5*period gives 01; < 7*period gives 10; otherwise 11.
REQ-016 SHALL reject a period outside [NOM/2, 3*NOM/2]: outputs unchanged, no sample_stb, line_err set, FSM stays in MEAS_HIGH and restarts counting.
REQ-017 SHALL treat a rise pulse in MEAS_HIGH (missed fall) as a rejected period per REQ-016.
REQ-018 SHALL ignore edges in WAIT_RISE other than a rise; the first period after reset or after a timeout is measured before the first update.
REQ-019 SHALL give a rise and the evaluation in the same cycle priority to evaluation, then the counter restart.

Reset
REQ-020 SHALL on reset_n low immediately clear: duty_sel=00, duty_valid=0, sample_stb=0, period_out=0, high_out=0, line_err=0, synchronizer FFs=0, counters=0, FSM=WAIT_RISE.
REQ-021 SHALL apply reset mid-period by discarding the partial measurement and producing no sample_stb.
REQ-022 SHALL clear line_err only by reset.

Configuration
REQ-023 SHALL implement macro PWM_DEC_TIMEOUT_EN as follows when defined: if no edge is seen for 3*NOM/2 consecutive cycles, a synchronized level of 1 forces duty_sel=11, duty_valid=1 and one sample_stb; a level of 0 forces duty_valid=0 and sets line_err. The FSM then goes to WAIT_RISE.
REQ-024 SHALL, when PWM_DEC_TIMEOUT_EN is undefined, include no timeout logic: a stuck line holds the last outputs indefinitely and 100% duty is never reported.

Structure
REQ-025 SHALL place duty code localparams (DUTY_25..DUTY_100), FSM state encodings and the classification constants 3/5/7 in shared package pwm_pkg, also used by the PWM generator.
REQ-026 SHALL implement the synchronizer and edge detector as sub-module pwm_sync_edge (ports clk, reset_n, d_in, level, rise, fall).

Verification
REQ-027 SHALL have the bench use CLK_FREQ_HZ=1000, PWM_FREQ_HZ=10 (NOM=100); all scenarios below use that setting.
REQ-028 SHALL verify: period 100, high 25, three periods -> duty_sel=00, period_out=100, high_out=25, one sample_stb per period after the first.
REQ-029 SHALL verify: high 75, then high 40 -> duty_sel=10 then 01 (40*8=320 >= 300); duty_valid stays 1.
REQ-030 SHALL verify: one period of 40 cycles (< NOM/2) between periods of 100 -> no update for it, line_err=1, next period of 100 updates normally.
REQ-031 SHALL verify with PWM_DEC_TIMEOUT_EN: pwm_in held 1 for 150 cycles -> duty_sel=11, sample_stb once; held 0 for 150 cycles -> duty_valid=0, line_err=1.
REQ-032 SHALL verify: reset_n pulsed low at cycle 60 of a period -> all outputs 0 immediately; first sample_stb only after two full rises post-reset.
